// File: rtl/uart_tx_en.sv
// uart_tx_en: oversampled 8N1 UART transmitter gated by an oversample tick.
// One bit period is Oversample pulses of en. A byte is taken on valid && ready
// (independent of en) and shifted out LSB first on a registered line.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high, ready for a byte
// S_START  | driving the start bit (0)
// S_DATA   | driving shift_q[0]; bit_cnt_q data bits remain after this one
// S_PARITY | driving the even-parity bit (UART_TX_PARITY_EN only)
// S_STOP   | driving the stop bit (1); done pulses when it ends
module uart_tx_en #(
  parameter int Oversample = 16
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       en,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       out,
  output logic       busy,
  output logic       done
);

  localparam int CW = (Oversample > 1) ? $clog2(Oversample) : 1;
  localparam logic [CW-1:0] SAMPLE_RELOAD = CW'(Oversample - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,S_PARITY = 3'd4
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            out_q, out_d;
  logic            done_q, done_d;
  logic            bit_end;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign bit_end = en && (sample_cnt_q == '0);

  // State and datapath registers; reset forces the line high immediately.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= SAMPLE_RELOAD;
      bit_cnt_q    <= 3'd7;
      shift_q      <= 8'h00;
      out_q        <= 1'b1;
      done_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      out_q        <= out_d;
      done_q       <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE regardless of en, otherwise advance on en.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    if (state_q == S_IDLE) begin
      if (valid) begin
        state_d      = S_START;
        sample_cnt_d = SAMPLE_RELOAD;
        bit_cnt_d    = 3'd7;
        shift_d      = data;
`ifdef UART_TX_PARITY_EN
        parity_d     = ^data;
`endif
      end
    end else if (en) begin
      if (bit_end) begin
        sample_cnt_d = SAMPLE_RELOAD;
        case (state_q)
          S_START: state_d = S_DATA;
          S_DATA: begin
            if (bit_cnt_q != 3'd0) begin
              shift_d   = {1'b0, shift_q[7:1]};
              bit_cnt_d = bit_cnt_q - 3'd1;
            end else begin
`ifdef UART_TX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: state_d = S_STOP;
`endif
          S_STOP:  state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end else begin
        sample_cnt_d = sample_cnt_q - CW'(1);
      end
    end
  end

  // Output logic: the line register follows the state being entered, so it
  // changes exactly on the edge that starts each bit.
  always_comb begin
    out_d = 1'b1;
    case (state_d)
      S_START:  out_d = 1'b0;
      S_DATA:   out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: out_d = parity_d;
`endif
      default:  out_d = 1'b1;
    endcase
    done_d = (state_q == S_STOP) && bit_end;
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = ~ready;
  assign out   = out_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_en.sv
// Testbench for uart_tx_en: per-cycle comparison against a frame-level model
// (pulse counting over a list of frame bits), table-driven frames, hand-written
// reset/back-to-back sequences and randomized traffic.
module tb_uart_tx_en;
  localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       nReset;
  logic       en;
  logic       valid;
  logic [7:0] data;
  logic       ready, out, busy, done;

  int errors = 0;
  int checks = 0;

  uart_tx_en #(.Oversample(OS)) dut (
    .clk(clk), .nReset(nReset), .en(en), .valid(valid), .data(data),
    .ready(ready), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a list of NB bit values, each lasting OS en pulses.
  bit m_active;
  int m_pulses;
  bit m_frame[NB];
  bit m_out;
  bit m_done;

  task automatic m_reset();
    m_active = 1'b0;
    m_pulses = 0;
    m_out    = 1'b1;
    m_done   = 1'b0;
  endtask

  task automatic m_edge(input bit v, input logic [7:0] d, input bit e);
    m_done = 1'b0;
    if (!m_active) begin
      if (v) begin
        m_active   = 1'b1;
        m_pulses   = 0;
        m_frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_frame[1+i] = d[i];
        if (NB == 11) m_frame[9] = ^d;
        m_frame[NB-1] = 1'b1;
        m_out = 1'b0;
      end else begin
        m_out = 1'b1;
      end
    end else if (e) begin
      m_pulses++;
      if (m_pulses == NB * OS) begin
        m_active = 1'b0;
        m_done   = 1'b1;
        m_out    = 1'b1;
      end else begin
        m_out = m_frame[m_pulses / OS];
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit e);
    valid = v;
    data  = d;
    en    = e;
    @(posedge clk);
    m_edge(v, d, e);
    #1;
    check("out",   32'(out),   32'(m_out));
    check("ready", 32'(ready), 32'(!m_active));
    check("busy",  32'(busy),  32'(m_active));
    check("done",  32'(done),  32'(m_done));
  endtask

  typedef struct {
    logic [7:0] data;
    int         en_period;
    int         exp_len;
  } vec_t;

  vec_t vecs[6];

  // Sends one byte with en every en_period clocks, measures accept-to-done and
  // decodes the line at mid-bit.
  task automatic run_vec(input vec_t v);
    int        len;
    bit [NB-1:0] rx;
    len = -1;
    rx  = '0;
    step(1'b1, v.data, 1'b1);
    for (int c = 1; c <= v.exp_len + 4 * OS && len < 0; c++) begin
      step(1'b0, 8'h00, (c % v.en_period) == 0);
      for (int b = 0; b < NB; b++)
        if (c == (b * OS + OS / 2) * v.en_period) rx[b] = out;
      if (done) len = c;
    end
    check("frame_len", 32'(len), 32'(v.exp_len));
    check("start_bit", 32'(rx[0]), 32'(0));
    check("rx_data",   32'(rx[8:1]), 32'(v.data));
    check("stop_bit",  32'(rx[NB-1]), 32'(1));
`ifdef UART_TX_PARITY_EN
    check("parity_bit", 32'(rx[9]), 32'(^v.data));
`endif
    step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    int len;
    vecs[0] = '{data: 8'hA5, en_period: 1, exp_len: NB * OS};
    vecs[1] = '{data: 8'h3C, en_period: 4, exp_len: NB * OS * 4};
    vecs[2] = '{data: 8'h00, en_period: 1, exp_len: NB * OS};
    vecs[3] = '{data: 8'hFF, en_period: 2, exp_len: NB * OS * 2};
    vecs[4] = '{data: 8'h55, en_period: 1, exp_len: NB * OS};
    vecs[5] = '{data: 8'h01, en_period: 3, exp_len: NB * OS * 3};

    // reset state
    nReset = 1'b0;
    en = 1'b0; valid = 1'b0; data = 8'h00;
    m_reset();
    #12;
    check("rst_out",   32'(out),   32'(1));
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_busy",  32'(busy),  32'(0));
    check("rst_done",  32'(done),  32'(0));
    @(negedge clk);
    nReset = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // table-driven frames
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // reset mid-frame: line must return high before any further clock edge
    step(1'b1, 8'hA5, 1'b1);
    for (int c = 1; c <= 40; c++) step(1'b0, 8'h00, 1'b1);
    #3;
    nReset = 1'b0;
    #1;
    check("midrst_out",   32'(out),   32'(1));
    check("midrst_ready", 32'(ready), 32'(1));
    check("midrst_busy",  32'(busy),  32'(0));
    check("midrst_done",  32'(done),  32'(0));
    m_reset();
    @(negedge clk);
    nReset = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    run_vec(vecs[0]);

    // busy-drop: 0xFF held valid during a 0x00 frame, taken right after done
    step(1'b1, 8'h00, 1'b1);
    len = -1;
    for (int c = 1; c <= NB * OS + 20 && len < 0; c++) begin
      step(1'b1, 8'hFF, 1'b1);
      if (done) len = c;
    end
    check("busydrop_len", 32'(len), 32'(NB * OS));
    step(1'b1, 8'hFF, 1'b1);
    check("b2b_start_out", 32'(out),   32'(0));
    check("b2b_ready",     32'(ready), 32'(0));
    len = -1;
    for (int c = 1; c <= NB * OS + 20 && len < 0; c++) begin
      step(1'b0, 8'h00, 1'b1);
      if (done) len = c;
    end
    check("b2b_len", 32'(len), 32'(NB * OS));

    // randomized traffic at several en densities
    for (int dens = 0; dens < 4; dens++) begin
      for (int k = 0; k < 800; k++) begin
        step($urandom_range(0, 1) == 1, 8'($urandom),
             (dens == 0) ? 1'b1 : ($urandom_range(0, dens) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
